// File: rtl/centroid_updater.sv
// centroid_updater
//
// Purpose: accumulates per-cluster coordinate sums and point counts from the
// closest-core assignments of the distance stage. At the end of a pass it
// computes each cluster's floor mean with a pair of restoring dividers (x and
// y in parallel) and updates the centroid table. It reports whether any
// centroid moved, so the K-means controller can detect convergence.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a pass, clear accumulators (IDLE only)
//   pt_valid/pt_ready      point handshake; ready only while accumulating
//   pt_x, pt_y, pt_core    point coordinates and its closest-core index
//   pass_done              no more points this pass (ACCUM only)
//   init_we/idx/x/y        centroid table write (IDLE only)
//   rd_idx -> rd_x, rd_y   combinational centroid table read port
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse at the end of the update
//   changed                some centroid moved (valid with done, held)
//   overflow               sticky: a point was dropped on counter saturation
module centroid_updater #(
  parameter int K       = 16,
  parameter int COORD_W = 8,
  parameter int CNT_W   = 10,
  parameter int SUM_W   = COORD_W + CNT_W,
  parameter int IDX_W   = $clog2(K)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic [IDX_W-1:0]   pt_core,
  input  logic               pass_done,
  input  logic               init_we,
  input  logic [IDX_W-1:0]   init_idx,
  input  logic [COORD_W-1:0] init_x,
  input  logic [COORD_W-1:0] init_y,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               busy,
  output logic               done,
  output logic               changed,
  output logic               overflow
);

  localparam int BIT_W = $clog2(SUM_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DIV_LOAD,
    S_DIV_RUN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t state;

  logic [COORD_W-1:0] cent_x [K];
  logic [COORD_W-1:0] cent_y [K];
  logic [SUM_W-1:0]   sum_x  [K];
  logic [SUM_W-1:0]   sum_y  [K];
  logic [CNT_W-1:0]   cnt    [K];

  logic [IDX_W-1:0] k;
  logic [BIT_W-1:0] bit_cnt;

  // Divider state: dq starts as the dividend and has quotient bits shifted in
  // at the bottom, so after SUM_W steps it holds the full quotient.
  logic [SUM_W-1:0] dq_x, dq_y;
  logic [CNT_W-1:0] rem_x, rem_y;
  logic [CNT_W-1:0] divisor;

  logic [CNT_W:0] trial_x, trial_y;
  logic [CNT_W:0] diff_x, diff_y;
  logic           ge_x, ge_y;

  logic [COORD_W-1:0] quo_x, quo_y;
  logic               last_k;

  assign rd_x     = cent_x[rd_idx];
  assign rd_y     = cent_y[rd_idx];
  assign pt_ready = (state == S_ACCUM);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign last_k   = (k == IDX_W'(K - 1));

  // Quotient always fits in a coordinate; the discarded upper bits are zero.
  assign quo_x = dq_x[COORD_W-1:0];
  assign quo_y = dq_y[COORD_W-1:0];

  // One restoring-division step. The remainder stays below the divisor, so
  // it fits CNT_W bits and the shifted trial value fits CNT_W+1 bits.
  always_comb begin
    trial_x = {rem_x, dq_x[SUM_W-1]};
    trial_y = {rem_y, dq_y[SUM_W-1]};
    diff_x  = trial_x - {1'b0, divisor};
    diff_y  = trial_y - {1'b0, divisor};
    ge_x    = (trial_x >= {1'b0, divisor});
    ge_y    = (trial_y >= {1'b0, divisor});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      bit_cnt  <= '0;
      dq_x     <= '0;
      dq_y     <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      divisor  <= '0;
      changed  <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < K; i++) begin
        cent_x[i] <= '0;
        cent_y[i] <= '0;
        sum_x[i]  <= '0;
        sum_y[i]  <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (init_we) begin
            cent_x[init_idx] <= init_x;
            cent_y[init_idx] <= init_y;
          end
          if (start) begin
            for (int i = 0; i < K; i++) begin
              sum_x[i] <= '0;
              sum_y[i] <= '0;
              cnt[i]   <= '0;
            end
            changed  <= 1'b0;
            overflow <= 1'b0;
            k        <= '0;
            state    <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (pt_valid) begin
            // A saturated counter drops the point entirely so the mean of
            // the points that were kept stays exact.
            if (cnt[pt_core] == {CNT_W{1'b1}}) begin
              overflow <= 1'b1;
            end else begin
              sum_x[pt_core] <= sum_x[pt_core] + SUM_W'(pt_x);
              sum_y[pt_core] <= sum_y[pt_core] + SUM_W'(pt_y);
              cnt[pt_core]   <= cnt[pt_core] + CNT_W'(1);
            end
          end
          if (pass_done) begin
            k     <= '0;
            state <= S_DIV_LOAD;
          end
        end

        S_DIV_LOAD: begin
          // Empty clusters keep their old centroid and cost one cycle.
          if (cnt[k] == '0) begin
            if (last_k) begin
              state <= S_FIN;
            end else begin
              k <= k + IDX_W'(1);
            end
          end else begin
            dq_x    <= sum_x[k];
            dq_y    <= sum_y[k];
            rem_x   <= '0;
            rem_y   <= '0;
            divisor <= cnt[k];
            bit_cnt <= '0;
            state   <= S_DIV_RUN;
          end
        end

        S_DIV_RUN: begin
          rem_x <= ge_x ? diff_x[CNT_W-1:0] : trial_x[CNT_W-1:0];
          rem_y <= ge_y ? diff_y[CNT_W-1:0] : trial_y[CNT_W-1:0];
          dq_x  <= {dq_x[SUM_W-2:0], ge_x};
          dq_y  <= {dq_y[SUM_W-2:0], ge_y};
          if (bit_cnt == BIT_W'(SUM_W - 1)) begin
            state <= S_WRITE;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end

        S_WRITE: begin
          if ((quo_x != cent_x[k]) || (quo_y != cent_y[k])) begin
            changed <= 1'b1;
          end
          cent_x[k] <= quo_x;
          cent_y[k] <= quo_y;
          if (last_k) begin
            state <= S_FIN;
          end else begin
            k     <= k + IDX_W'(1);
            state <= S_DIV_LOAD;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
